// File: rtl/present_nf_pkg.sv
// Shared types and constants for the NullFresh masked PRESENT-80 round controller.
package present_nf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PRESENT_ROUNDS = 31;
    localparam int RC_W           = 5;
    localparam int KEY_W          = 80;
    localparam int BLK_W          = 64;
    localparam int SHARES         = 3;

endpackage

// File: rtl/nf_stage_seq.sv
// Stage sequencer for the masked S-box pipeline: walks one enable bit through
// SBOX_STAGES pipeline stages and flags the last stage of each round.
module nf_stage_seq
    import present_nf_pkg::*;
#(
    parameter int SBOX_STAGES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_active,
    input  logic                   i_flush,
    output logic [SBOX_STAGES-1:0] o_stage_en,
    output logic                   o_last
);

    localparam int CNT_W = $clog2(SBOX_STAGES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SBOX_STAGES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    // The last-stage flag is only meaningful while a round is in flight.
    assign w_last = i_active && (r_cnt == LAST_CNT);
    assign o_last = w_last;

    // Advance through the stages during a round; park at stage 0 when idle, flushed or wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_active || i_flush || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // One-hot decode of the registered counter, so at most one stage is ever enabled.
    for (genvar k = 0; k < SBOX_STAGES; k++) begin : g_stage_dec
        assign o_stage_en[k] = i_active && (r_cnt == CNT_W'(k));
    end

endmodule

// File: rtl/present_nf_round_ctrl.sv
// Round sequencer for the 3-share NullFresh masked PRESENT-80 core.
// Optional feature: define PRESENT_NF_ABORT_EN to add the abort input and clr output.
// Everything except in_ready/load_en is decoded from registered state.
module present_nf_round_ctrl
    import present_nf_pkg::*;
#(
    parameter int SBOX_STAGES = 4,
    parameter int ROUNDS      = PRESENT_ROUNDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   load_en,
    output logic [SBOX_STAGES-1:0] stage_en,
    output logic                   round_en,
    output logic [RC_W-1:0]        round_cnt,
    output logic                   last_round,
`ifdef PRESENT_NF_ABORT_EN
    input  logic                   abort,
    output logic                   clr,
`endif
    output logic                   busy
);

    // Elaboration-time parameter range checks.
    if ((ROUNDS < 1) || (ROUNDS > ((1 << RC_W) - 1))) begin : g_bad_rounds
        $error("present_nf_round_ctrl: ROUNDS must fit in the 5-bit round counter");
    end
    if ((SBOX_STAGES < 2) || (SBOX_STAGES > 8)) begin : g_bad_stages
        $error("present_nf_round_ctrl: SBOX_STAGES must be within 2..8");
    end

    localparam logic [RC_W-1:0] LAST_RC = RC_W'(ROUNDS);

    state_t          r_state;
    logic [RC_W-1:0] r_round_cnt;
    logic            w_run;
    logic            w_abort;
    logic            w_last_stage;

    assign w_run = (r_state == RUN);

`ifdef PRESENT_NF_ABORT_EN
    logic r_clr;

    // Abort is only honoured while a block is in flight or waiting for delivery.
    assign w_abort = abort && (r_state != IDLE);

    // One-cycle clear pulse to the wrapper after an abort has been taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr <= 1'b0;
        end else begin
            r_clr <= w_abort;
        end
    end

    assign clr = r_clr;
`else
    assign w_abort = 1'b0;
`endif

    nf_stage_seq #(
        .SBOX_STAGES (SBOX_STAGES)
    ) u_stage_seq (
        .clk        (clk),
        .rst        (rst),
        .i_active   (w_run),
        .i_flush    (w_abort),
        .o_stage_en (stage_en),
        .o_last     (w_last_stage)
    );

    // Controller FSM: accept in IDLE, count rounds in RUN, hold result in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_round_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state     <= RUN;
                        r_round_cnt <= RC_W'(1);
                    end else begin
                        r_state     <= IDLE;
                        r_round_cnt <= '0;
                    end
                end
                RUN: begin
                    if (w_abort) begin
                        r_state     <= IDLE;
                        r_round_cnt <= '0;
                    end else if (w_last_stage) begin
                        if (r_round_cnt == LAST_RC) begin
                            r_state <= DONE;
                        end else begin
                            r_round_cnt <= r_round_cnt + RC_W'(1);
                        end
                    end else begin
                        r_state <= RUN;
                    end
                end
                DONE: begin
                    if (w_abort || out_ready) begin
                        r_state     <= IDLE;
                        r_round_cnt <= '0;
                    end else begin
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_round_cnt <= '0;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign load_en    = in_ready && in_valid;
    assign out_valid  = (r_state == DONE);
    assign round_en   = w_last_stage;
    assign round_cnt  = r_round_cnt;
    assign last_round = (r_round_cnt == LAST_RC);
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_present_nf_round_ctrl.sv
// Directed bench for present_nf_round_ctrl (default 4-stage instance plus a
// 2-stage instance for back-to-back blocks). Abort checks need PRESENT_NF_ABORT_EN.
module tb_present_nf_round_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic       in_ready;
    logic       out_valid;
    logic       load_en;
    logic [3:0] stage_en;
    logic       round_en;
    logic [4:0] round_cnt;
    logic       last_round;
    logic       busy;
`ifdef PRESENT_NF_ABORT_EN
    logic       abort;
    logic       clr;
    logic       b_abort;
    logic       b_clr;
`endif

    logic       b_in_valid;
    logic       b_out_ready;
    logic       b_in_ready;
    logic       b_out_valid;
    logic       b_load_en;
    logic [1:0] b_stage_en;
    logic       b_round_en;
    logic [4:0] b_round_cnt;
    logic       b_last_round;
    logic       b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    present_nf_round_ctrl #(.SBOX_STAGES(4), .ROUNDS(31)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .load_en    (load_en),
        .stage_en   (stage_en),
        .round_en   (round_en),
        .round_cnt  (round_cnt),
        .last_round (last_round),
`ifdef PRESENT_NF_ABORT_EN
        .abort      (abort),
        .clr        (clr),
`endif
        .busy       (busy)
    );

    present_nf_round_ctrl #(.SBOX_STAGES(2), .ROUNDS(31)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .load_en    (b_load_en),
        .stage_en   (b_stage_en),
        .round_en   (b_round_en),
        .round_cnt  (b_round_cnt),
        .last_round (b_last_round),
`ifdef PRESENT_NF_ABORT_EN
        .abort      (b_abort),
        .clr        (b_clr),
`endif
        .busy       (b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_a();
        in_valid = 1'b1;
        #1;
        chk("acc_load_en", 32'(load_en), 32'd1);
        chk("acc_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Structural invariants checked on every falling edge for both instances.
    always @(negedge clk) begin
        if (!rst) begin
            chk("a_onehot0", 32'($onehot0(stage_en)), 32'd1);
            chk("a_stage_vs_load", 32'((|stage_en) && load_en), 32'd0);
            chk("a_round_en_stage", 32'(round_en && !stage_en[3]), 32'd0);
            chk("b_onehot0", 32'($onehot0(b_stage_en)), 32'd1);
            chk("b_stage_vs_load", 32'((|b_stage_en) && b_load_en), 32'd0);
            chk("b_round_en_stage", 32'(b_round_en && !b_stage_en[1]), 32'd0);
        end
    end

    initial begin
        logic seen_re;
        logic seen_ov;
        logic seen_clr;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
`ifdef PRESENT_NF_ABORT_EN
        abort       = 1'b0;
        b_abort     = 1'b0;
`endif
        tick();
        tick();

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_load_en", 32'(load_en), 32'd0);
        chk("rst_stage_en", 32'(stage_en), 32'd0);
        chk("rst_round_en", 32'(round_en), 32'd0);
        chk("rst_round_cnt", 32'(round_cnt), 32'd0);
        chk("rst_last_round", 32'(last_round), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Full block, every cycle checked; in_valid pulsed mid-run must be ignored
        accept_a();
        for (int k = 0; k < 124; k++) begin
            chk("run_stage_en", 32'(stage_en), 32'(4'b0001 << (k % 4)));
            chk("run_round_en", 32'(round_en), 32'((k % 4) == 3));
            chk("run_round_cnt", 32'(round_cnt), 32'((k / 4) + 1));
            chk("run_last_round", 32'(last_round), 32'(((k / 4) + 1) == 31));
            chk("run_out_valid", 32'(out_valid), 32'd0);
            chk("run_load_en", 32'(load_en), 32'd0);
            chk("run_in_ready", 32'(in_ready), 32'd0);
            chk("run_busy", 32'(busy), 32'd1);
            in_valid = (k == 50);
            tick();
        end
        in_valid = 1'b0;

        // DONE held for 10 cycles with out_ready low and in_valid high
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("done_out_valid", 32'(out_valid), 32'd1);
            chk("done_round_cnt", 32'(round_cnt), 32'd31);
            chk("done_last_round", 32'(last_round), 32'd1);
            chk("done_in_ready", 32'(in_ready), 32'd0);
            chk("done_load_en", 32'(load_en), 32'd0);
            chk("done_stage_en", 32'(stage_en), 32'd0);
            chk("done_round_en", 32'(round_en), 32'd0);
            chk("done_busy", 32'(busy), 32'd1);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_in_ready", 32'(in_ready), 32'd1);
        chk("hs_out_valid", 32'(out_valid), 32'd0);
        chk("hs_round_cnt", 32'(round_cnt), 32'd0);
        chk("hs_busy", 32'(busy), 32'd0);

        // Asynchronous reset between edges in round 17
        accept_a();
        repeat (64) tick();
        chk("r17_round_cnt", 32'(round_cnt), 32'd17);
        chk("r17_stage_en", 32'(stage_en), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_round_cnt", 32'(round_cnt), 32'd0);
        chk("arst_stage_en", 32'(stage_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_last_round", 32'(last_round), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        accept_a();
        chk("clean_round_cnt", 32'(round_cnt), 32'd1);
        chk("clean_stage_en", 32'(stage_en), 32'd1);
        repeat (123) tick();
        chk("lat_before", 32'(out_valid), 32'd0);
        tick();
        chk("lat_at_124", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("clean_back_idle", 32'(in_ready), 32'd1);

`ifdef PRESENT_NF_ABORT_EN
        // Abort coinciding with the round-5 round_en
        accept_a();
        repeat (19) tick();
        chk("ab_round_cnt", 32'(round_cnt), 32'd5);
        chk("ab_round_en", 32'(round_en), 32'd1);
        chk("ab_clr_pre", 32'(clr), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_clr", 32'(clr), 32'd1);
        chk("ab_in_ready", 32'(in_ready), 32'd1);
        chk("ab_round_cnt0", 32'(round_cnt), 32'd0);
        chk("ab_round_en0", 32'(round_en), 32'd0);
        tick();
        chk("ab_clr_once", 32'(clr), 32'd0);
        seen_re  = 1'b0;
        seen_ov  = 1'b0;
        seen_clr = 1'b0;
        repeat (130) begin
            tick();
            seen_re  = seen_re | round_en;
            seen_ov  = seen_ov | out_valid;
            seen_clr = seen_clr | clr;
        end
        chk("ab_no_round_en", 32'(seen_re), 32'd0);
        chk("ab_no_out_valid", 32'(seen_ov), 32'd0);
        chk("ab_no_more_clr", 32'(seen_clr), 32'd0);
        // Abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_idle_clr", 32'(clr), 32'd0);
        chk("ab_idle_ready", 32'(in_ready), 32'd1);
`endif

        // Two-stage instance: back-to-back blocks, out_ready tied high
        b_in_valid = 1'b1;
        #1;
        chk("b_acc_load_en", 32'(b_load_en), 32'd1);
        tick();
        chk("b_first_cnt", 32'(b_round_cnt), 32'd1);
        chk("b_first_stage", 32'(b_stage_en), 32'd1);
        repeat (61) tick();
        chk("b_lat_before", 32'(b_out_valid), 32'd0);
        tick();
        chk("b_lat_62", 32'(b_out_valid), 32'd1);
        chk("b_done_cnt", 32'(b_round_cnt), 32'd31);
        tick();
        chk("b_hs_ready", 32'(b_in_ready), 32'd1);
        chk("b_hs_load", 32'(b_load_en), 32'd1);
        chk("b_hs_out_valid", 32'(b_out_valid), 32'd0);
        tick();
        chk("b_second_busy", 32'(b_busy), 32'd1);
        chk("b_second_cnt", 32'(b_round_cnt), 32'd1);
        chk("b_second_stage", 32'(b_stage_en), 32'd1);
        repeat (61) tick();
        chk("b2_lat_before", 32'(b_out_valid), 32'd0);
        tick();
        chk("b2_lat_62", 32'(b_out_valid), 32'd1);
        b_in_valid = 1'b0;
        tick();
        chk("b2_idle", 32'(b_in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/present_nf_round_ctrl.md
Name: present_nf_round_ctrl

Overview:
- Round sequencer for the round-based, second-order (3-share) NullFresh masked PRESENT-80 encryption core.
- Drives load, S-box pipeline stage enables, state/key register updates and the key-schedule round counter.
- Handshakes plaintext/key acceptance and ciphertext delivery with the surrounding wrapper.
- Contains no datapath. Share data never passes through this block.

Parameters:
- SBOX_STAGES, 4, number of register stages in the masked S-box pipeline (component-function layers plus output layer); legal range 2..8.
- ROUNDS, 31, number of PRESENT rounds before final key addition.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  plaintext and key shares present at datapath inputs.
- in_ready  out  1  controller idle and able to accept.
- out_valid  out  1  ciphertext shares valid at datapath outputs.
- out_ready  in  1  consumer takes ciphertext.
- load_en  out  1  state/key registers capture input shares.
- stage_en  out  SBOX_STAGES  one-hot enable of S-box pipeline stage k.
- round_en  out  1  state captures pLayer output; key register applies key schedule.
- round_cnt  out  5  current round number (1..ROUNDS), fed to key-schedule counter XOR.
- last_round  out  1  high while round_cnt==ROUNDS.
- busy  out  1  high in RUN and DONE.

Behaviour:
- Reset: async, active-high. Forces the FSM to IDLE, stage counter 0 and round_cnt 0. All outputs are 0 except in_ready=1. Reset mid-operation discards the computation; no partial out_valid.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1; load_en = in_valid (combinational).
  - On in_valid at a clock edge: round_cnt←1, stage counter←0, go to RUN.
- RUN:
  - in_ready=0; stage_en[cnt]=1 and all other bits 0.
  - When cnt==SBOX_STAGES-1: round_en=1 that cycle, cnt←0.
  - At that same point: if round_cnt==ROUNDS, go to DONE; otherwise round_cnt←round_cnt+1.
  - In every other RUN cycle: cnt←cnt+1.
- DONE:
  - out_valid=1 and is held until out_ready=1; all enables 0.
  - round_cnt holds ROUNDS. The final key XOR is combinational in the datapath.
  - On out_ready: go to IDLE, round_cnt←0.
- Latency: out_valid rises on rising edge number ROUNDS·SBOX_STAGES after the accepting edge, i.e. 124 for the defaults.
- Throughput: one block per ROUNDS·SBOX_STAGES+2 cycles minimum.
- Glitch hygiene:
  - All outputs except load_en and in_ready are decoded from registered state only.
  - Never assert two stage_en bits, or stage_en together with load_en, in the same cycle.
- in_valid is ignored outside IDLE.
- out_ready is ignored outside DONE.
- round_cnt never wraps: the ROUNDS→1 transition only happens through IDLE.
- Width: cnt is $clog2(SBOX_STAGES) bits. round_cnt is 5 bits, with ROUNDS ≤ 31 checked by an elaboration assertion.

Optional Feature:
- Macro: PRESENT_NF_ABORT_EN.
- Defined:
  - Adds port abort (in, 1).
  - abort=1 in RUN or DONE goes to IDLE at the next edge; round_cnt←0, no out_valid.
  - Adds output clr (out, 1), a one-cycle pulse in the cycle after an abort is taken, so the wrapper zeroes state, key and pipeline share registers.
  - abort has priority over a round_en transition and over out_ready in the same cycle.
  - abort in IDLE is ignored.
- Undefined: neither port exists and the behaviour is exactly as above.

Decomposition:
- Shared package present_nf_pkg:
  - state enum {IDLE, RUN, DONE}.
  - localparams PRESENT_ROUNDS=31, RC_W=5, KEY_W=80, BLK_W=64, SHARES=3.
- One sub-module, nf_stage_seq:
  - Stage counter with one-hot stage_en decode and last-stage flag.
  - Parameterised by SBOX_STAGES.
  - Instantiated once.

Test Plan:
- Defaults; reset, then in_valid=1 for one cycle.
  - load_en is high only in the accept cycle.
  - stage_en cycles 0001→0010→0100→1000.
  - round_en pulses at cycles 4, 8, … 124 after accept.
  - round_cnt steps 1..31; out_valid rises after edge 124.
- Hold out_ready=0 for 10 cycles in DONE.
  - out_valid, round_cnt=31 and last_round=1 remain stable.
  - in_ready=0 and in_valid is ignored.
  - out_ready=1 returns the FSM to IDLE in 1 cycle.
- Assert rst asynchronously in RUN at round 17, between edges.
  - Outputs immediately read 0, with in_ready=1 and round_cnt=0.
  - The next in_valid starts a clean round 1.
- SBOX_STAGES=2, back-to-back blocks with out_ready tied to 1.
  - 62-cycle latency per block.
  - The second accept occurs 1 cycle after the first out_valid handshake.
- Full-run assertions:
  - $onehot0(stage_en) in every cycle.
  - No stage_en together with load_en.
  - round_en only when stage_en[SBOX_STAGES-1]=1.
- With PRESENT_NF_ABORT_EN defined, pulse abort at round 5 together with round_en.
  - No further round_en; clr pulses once on the next cycle.
  - IDLE is reached and out_valid is never asserted.
